// File: rtl/sprite_bus_pkg.sv
// sprite_bus_pkg: shared widths, sprite/score register map, update record and master FSM states
package sprite_bus_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_ADDR_W-1:0] DINO_X  = 9'd0;
  localparam logic [DEF_ADDR_W-1:0] DINO_Y  = 9'd1;
  localparam logic [DEF_ADDR_W-1:0] JUMP_X  = 9'd2;
  localparam logic [DEF_ADDR_W-1:0] JUMP_Y  = 9'd3;
  localparam logic [DEF_ADDR_W-1:0] DUCK_X  = 9'd4;
  localparam logic [DEF_ADDR_W-1:0] DUCK_Y  = 9'd5;
  localparam logic [DEF_ADDR_W-1:0] SCAC_X  = 9'd6;
  localparam logic [DEF_ADDR_W-1:0] SCAC_Y  = 9'd7;
  localparam logic [DEF_ADDR_W-1:0] GODZ_X  = 9'd8;
  localparam logic [DEF_ADDR_W-1:0] GODZ_Y  = 9'd9;
  localparam logic [DEF_ADDR_W-1:0] SCORE   = 9'd10;
  localparam logic [DEF_ADDR_W-1:0] SCORE_X = 9'd11;
  localparam logic [DEF_ADDR_W-1:0] SCORE_Y = 9'd12;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } update_t;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, head / next-head peek and tail overwrite
// Ports: clk, reset (async, active-low), push/din, pop, ovw (rewrite newest entry with din),
//        head, head_nxt, tail (newest entry), count.
module sync_fifo
  import sprite_bus_pkg::*;
#(
  parameter type T     = update_t,
  parameter int  DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   ovw,
  input  T                       din,
  output T                       head,
  output T                       head_nxt,
  output T                       tail,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign head = mem[rp];
  assign head_nxt = mem[rp + 1'b1];
  assign tail = mem[wp - 1'b1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
    else if (ovw) mem[wp - 1'b1] <= din;
endmodule

// File: rtl/sprite_update_master.sv
// sprite_update_master: queues sprite/score register updates and writes them over Avalon-MM only during vblank
// Ports: clk, reset (async, active-low), vblank, in_valid/in_ready/in_addr/in_data (update push),
//        av_chipselect/av_write/av_address/av_writedata/av_waitrequest (Avalon write initiator),
//        fifo_count, overflow (sticky, cleared by clear_ovf), frame_count (vblank rises, wraps).
// Optional: SPRITE_UPDATE_COALESCE_EN merges a push into the newest queued entry with the same address.
module sprite_update_master
  import sprite_bus_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int MAX_PER_FRAME = 32,
  parameter int WRITE_GAP     = 1,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vblank,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   av_chipselect,
  output logic                   av_write,
  output logic [ADDR_W-1:0]      av_address,
  output logic [DATA_W-1:0]      av_writedata,
  input  logic                   av_waitrequest,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clear_ovf,
  output logic [15:0]            frame_count
);
  localparam int W  = ADDR_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAX_PER_FRAME + 1);
  localparam int GW = WRITE_GAP > 1 ? $clog2(WRITE_GAP) : 1;
  state_t state;
  logic vblank_q, rise, pop, push, drop, coal, load, cont_i, cont_g, gap_done, unused;
  logic [BW-1:0] budget;
  logic [GW-1:0] gap_cnt;
  logic [W-1:0] head, head_nxt, tail, ld;
  assign in_ready = fifo_count != CW'(DEPTH);
  assign rise = vblank && !vblank_q;
  assign pop = state == ISSUE && !av_waitrequest;
  // back-to-back continuation must look past the entry being popped this cycle
  assign cont_i = fifo_count > CW'(1) && vblank && int'(budget) + 1 < MAX_PER_FRAME;
  assign cont_g = fifo_count != '0 && vblank && int'(budget) < MAX_PER_FRAME;
  assign gap_done = int'(gap_cnt) >= WRITE_GAP - 1;
  assign load = state == IDLE  ? rise && fifo_count != '0 :
                state == ISSUE ? pop && WRITE_GAP == 0 && cont_i :
                                 gap_done && cont_g;
  assign ld = state == ISSUE ? head_nxt : head;
`ifdef SPRITE_UPDATE_COALESCE_EN
  // never rewrite an entry that is on the bus or being latched onto it this cycle
  assign coal = in_valid && fifo_count != '0 && tail[W-1 -: ADDR_W] == in_addr &&
                !(fifo_count == CW'(1) && (state == ISSUE || load)) &&
                !(load && state == ISSUE && fifo_count == CW'(2));
  assign unused = ^tail[DATA_W-1:0];
`else
  assign coal = 1'b0;
  assign unused = ^tail;
`endif
  assign push = in_valid && in_ready && !coal;
  assign drop = in_valid && !in_ready && !coal;
  sync_fifo #(.T(logic [W-1:0]), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .ovw      (coal),
    .din      ({in_addr, in_data}),
    .head     (head),
    .head_nxt (head_nxt),
    .tail     (tail),
    .count    (fifo_count)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      vblank_q <= 1'b0;
      frame_count <= '0;
      overflow <= 1'b0;
      budget <= '0;
      gap_cnt <= '0;
      av_chipselect <= 1'b0;
      av_write <= 1'b0;
      av_address <= '0;
      av_writedata <= '0;
    end else begin
      vblank_q <= vblank;
      frame_count <= frame_count + 16'(rise);
      overflow <= drop || (overflow && !clear_ovf);
      av_chipselect <= load || (av_chipselect && !pop);
      av_write <= load || (av_write && !pop);
      if (load) {av_address, av_writedata} <= ld;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      if (pop) budget <= budget + 1'b1;
      else if (state == IDLE && load) budget <= '0;
      case (state)
        IDLE:    state <= load ? ISSUE : IDLE;
        ISSUE:   state <= !pop ? ISSUE : WRITE_GAP > 0 ? GAP : load ? ISSUE : IDLE;
        default: state <= !gap_done ? GAP : load ? ISSUE : IDLE;
      endcase
    end
endmodule

// File: doc/sprite_update_master.md
Name: sprite_update_master

Overview:
- Avalon-MM write initiator that drives the sprite/score register file of the VGA display peripheral: the chipselect/write/address/writedata responder.
- Game logic pushes (address, data) register updates into a FIFO at any time.
- The block drains the FIFO only during vertical blanking, so sprite positions and score never change mid-frame (no tearing).
- Sits between the game-control logic and the display peripheral, on the same 50 MHz clock as the VGA counters.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- MAX_PER_FRAME, 32: maximum writes issued per vblank window.
- WRITE_GAP, 1: idle cycles inserted between consecutive writes; 0 allowed.
- ADDR_W, 9: register address width.
- DATA_W, 32: write data width.

Ports:
- clk in 1: system clock.
- reset in 1: asynchronous, active-low reset.
- vblank in 1: high while vcount is at or above the active height; synchronous to clk.
- in_valid in 1: update request.
- in_ready out 1: FIFO can accept.
- in_addr in ADDR_W: target register address.
- in_data in DATA_W: target register data.
- av_chipselect out 1: Avalon chipselect.
- av_write out 1: Avalon write strobe.
- av_address out ADDR_W: Avalon address.
- av_writedata out DATA_W: Avalon write data.
- av_waitrequest in 1: target stall; tie 0 if the target has none.
- fifo_count out $clog2(DEPTH)+1: current occupancy.
- overflow out 1: sticky flag; request dropped while full.
- clear_ovf in 1: clears overflow.
- frame_count out 16: vblank rising edges seen, wraps.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO emptied; FSM to IDLE.
  - av_chipselect=0, av_write=0, av_address=0, av_writedata=0.
  - overflow=0, frame_count=0, fifo_count=0; internal vblank_q=0.
- Push handshake:
  - in_ready = (fifo_count != DEPTH).
  - Entry accepted when in_valid && in_ready.
  - in_valid && !in_ready drops the request and sets overflow.
- overflow:
  - clear_ovf clears it.
  - A same-cycle set and clear: the set wins.
- Edge detect: vblank_q registers vblank; vblank_rise = vblank && !vblank_q. frame_count increments on each rise and wraps 0xFFFF to 0.
- FSM (outputs registered):
  - IDLE: on vblank_rise with FIFO non-empty, go to ISSUE and reset budget = 0. av_chipselect/av_write go high the cycle after the rise (latency 1), carrying the FIFO head.
  - ISSUE: hold chipselect, write, address and writedata stable while av_waitrequest=1. On the first cycle with waitrequest=0 the write completes, the head is popped and budget is incremented; chipselect/write drop the next cycle. Then:
    - go to GAP if WRITE_GAP>0;
    - else go directly back to ISSUE with the next head (back-to-back writes) if the continue condition holds;
    - else go to IDLE.
  - GAP: count WRITE_GAP cycles with strobes low. Then go to ISSUE if the continue condition holds, else IDLE.
  - Continue condition: FIFO non-empty && vblank==1 && budget < MAX_PER_FRAME.
- Boundaries:
  - vblank falling during ISSUE: the in-flight write completes and is never aborted; no new write starts.
  - FIFO empty at vblank_rise: frame counted, no writes.
  - Budget reached: remaining entries wait for the next vblank.
  - Push and pop in the same cycle: fifo_count unchanged. When full, a pop and a push in the same cycle are both honoured only if in_ready was high at the start of that cycle (in_ready is not combinationally dependent on the pop).
  - Entries issue in strict FIFO order.
  - Reset mid-write: strobes drop immediately; queued updates are lost.

Optional Feature:
- Macro SPRITE_UPDATE_COALESCE_EN.
- Defined: an accepted push whose in_addr equals the address of the most recently pushed entry still in the FIFO overwrites that entry's data. fifo_count is unchanged and in_ready is ignored for that push (no overflow).
  - Exception: this does not apply if that entry is the head currently held in ISSUE. In that case the push is a normal push.
- Undefined: every accepted push allocates a new entry.

Decomposition:
- Shared package sprite_bus_pkg:
  - ADDR_W and DATA_W defaults.
  - Register address constants: DINO_X=0, DINO_Y=1, JUMP_X=2, JUMP_Y=3, DUCK_X=4, DUCK_Y=5, SCAC_X=6, SCAC_Y=7, GODZ_X=8, GODZ_Y=9, SCORE=10, SCORE_X=11, SCORE_Y=12.
  - A packed struct update_t {addr, data}.
  - FSM state enum {IDLE, ISSUE, GAP}.
- One sub-module: sync_fifo, a parameterised single-clock FIFO of update_t with count output and tail-overwrite port (the port is used only under SPRITE_UPDATE_COALESCE_EN).

Test Plan:
- Push (0,100),(1,50),(10,3) with vblank=0 → no av_write. Raise vblank → three writes in order; 1 gap cycle apart at WRITE_GAP=1; first write the cycle after the rise. fifo_count returns to 0; frame_count=1.
- MAX_PER_FRAME=4 with 6 entries queued → 4 writes in frame 1, 2 writes in the next vblank. frame_count=2.
- Hold av_waitrequest=1 for 5 cycles on the first write while vblank falls → address/data stable for all 5 cycles, write completes, no second write.
- Fill 16 entries, push a 17th → in_ready=0, entry dropped, overflow=1. clear_ovf → overflow=0.
- Assert reset during ISSUE → strobes 0 immediately, fifo_count=0, frame_count=0, in_ready=1.
- With SPRITE_UPDATE_COALESCE_EN, push (0,10),(0,20),(0,30) → fifo_count=1; vblank yields a single write of address 0, data 30.
